// File: rtl/mul_div_pkg.sv
// mul_div_pkg -- shared definitions for the RV32M multiply/divide unit.
//   Operation select, operand-sign select and reset-level constants, the
//   FSM state encoding, and a conditional two's-complement helper used for
//   both operand magnitude conversion and result sign correction.
package mul_div_pkg;

   localparam int unsigned REG_W = 32;

   // Operation select on mul_or_div_i.
   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Operand sign select on reg1_sign_i / reg2_sign_i.
   localparam logic SIGN_SIGNED = 1'b1;

   // Level of rst that resets the block.
   localparam logic RST_ENABLE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Returns -v when neg is set, otherwise v.
   function automatic logic [REG_W-1:0] neg_if(input logic [REG_W-1:0] v,
                                               input logic             neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mul_div.sv
// mul_div -- radix-2 iterative RV32M multiply/divide responder.
//   One shift-add (multiply) or one restoring step (divide) per cycle,
//   32 iterations, then a one-cycle done pulse. Divide by zero and the
//   signed overflow case bypass the iterations.
// Ports:
//   clk           core clock
//   rst           synchronous reset, active low
//   start_i       request valid, held by the requester until done_o
//   mul_or_div_i  OP_MUL / OP_DIV
//   dividend_i    operand 1 (multiplicand or dividend)
//   divisor_i     operand 2 (multiplier or divisor)
//   reg1_sign_i   operand 1 is signed
//   reg2_sign_i   operand 2 is signed
//   flush_i       pipeline flush, aborts an operation in progress
//   result_o      multiply: 64-bit product; divide: {quotient, remainder}
//   done_o        one-cycle result-valid pulse
//   busy_o        unit is not idle
module mul_div
   import mul_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        mul_or_div_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic        reg1_sign_i,
   input  logic        reg2_sign_i,
   input  logic        flush_i,
   output logic [63:0] result_o,
   output logic        done_o,
   output logic        busy_o
);

   state_e      state;
   state_e      state_next;
   logic [4:0]  counter;
   logic [63:0] acc;        // mul: running product; div: {remainder, dividend/quotient}
   logic [63:0] op_a;       // mul: multiplicand, shifted left each step
   logic [31:0] op_b;       // mul: multiplier, shifted right; div: divisor magnitude
   logic        is_div;
   logic        neg_res;    // negate product (mul) or quotient (div)
   logic        neg_rem;    // negate remainder

   // Request decode, evaluated on the raw inputs in IDLE.
   logic        op1_neg;
   logic        op2_neg;
   logic [31:0] op1_mag;
   logic [31:0] op2_mag;
   logic        div_by_zero;
   logic        div_ovf;
   logic        accept;
   logic        abort;

   assign op1_neg     = (reg1_sign_i == SIGN_SIGNED) && dividend_i[31];
   assign op2_neg     = (reg2_sign_i == SIGN_SIGNED) && divisor_i[31];
   assign op1_mag     = neg_if(dividend_i, op1_neg);
   assign op2_mag     = neg_if(divisor_i, op2_neg);
   assign div_by_zero = (mul_or_div_i == OP_DIV) && (divisor_i == 32'd0);
   assign div_ovf     = (mul_or_div_i == OP_DIV) && op1_neg && op2_neg &&
                        (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
   assign accept      = (state == ST_IDLE) && start_i && !flush_i;
   assign abort       = (state == ST_CALC) && (!start_i || flush_i);

   // One iteration of either engine.
   logic [32:0] div_partial;
   logic        div_fits;
   logic [31:0] div_rem_sub;
   logic [63:0] div_next;
   logic [63:0] mul_next;
   logic [63:0] acc_next;
   logic [63:0] final_result;

   // Partial remainder with the next dividend bit appended.
   assign div_partial = acc[63:31];
   assign div_fits    = div_partial >= {1'b0, op_b};
   // When the divisor fits, the difference is below the divisor and fits 32 bits.
   assign div_rem_sub = div_partial[31:0] - op_b;
   assign div_next    = div_fits ? {div_rem_sub, acc[30:0], 1'b1}
                                 : {acc[62:0], 1'b0};
   assign mul_next    = op_b[0] ? (acc + op_a) : acc;
   assign acc_next    = is_div ? div_next : mul_next;

   assign final_result = is_div ? {neg_if(acc_next[31:0], neg_res),
                                   neg_if(acc_next[63:32], neg_rem)}
                                : (neg_res ? (~acc_next + 64'd1) : acc_next);

   // State register.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: a default is assigned first so no path leaves state_next unassigned (no latch).
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = (div_by_zero || div_ovf) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (counter == 5'd31) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         // NOTE: reset is synchronous and clears every datapath register, so outputs read zero after reset.
         counter  <= 5'd0;
         acc      <= 64'd0;
         op_a     <= 64'd0;
         op_b     <= 32'd0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         result_o <= 64'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  is_div  <= mul_or_div_i;
                  neg_res <= op1_neg ^ op2_neg;
                  neg_rem <= op1_neg;
                  counter <= 5'd0;
                  if (div_by_zero) begin
                     result_o <= {32'hFFFF_FFFF, dividend_i};
                  end else if (div_ovf) begin
                     result_o <= {32'h8000_0000, 32'h0000_0000};
                  end else begin
                     acc  <= (mul_or_div_i == OP_DIV) ? {32'd0, op1_mag} : 64'd0;
                     op_a <= {32'd0, op1_mag};
                     op_b <= op2_mag;
                  end
               end
            end
            ST_CALC: begin
               if (abort) begin
                  counter <= 5'd0;
               end else begin
                  acc     <= acc_next;
                  op_a    <= op_a << 1;
                  op_b    <= is_div ? op_b : (op_b >> 1);
                  counter <= counter + 5'd1;
                  if (counter == 5'd31) begin
                     result_o <= final_result;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign done_o = (state == ST_DONE);
   assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div -- directed self-checking bench for mul_div.
//   Outputs are sampled on the falling edge; inputs are driven there too.
module tb_mul_div;
   import mul_div_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mul_or_div = 1'b0;
   logic [31:0] dividend = 32'd0;
   logic [31:0] divisor = 32'd0;
   logic        reg1_sign = 1'b0;
   logic        reg2_sign = 1'b0;
   logic        flush = 1'b0;
   logic [63:0] result;
   logic        done;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int last_busy = 0;

   always #5 clk = ~clk;

   mul_div dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .mul_or_div_i (mul_or_div),
      .dividend_i   (dividend),
      .divisor_i    (divisor),
      .reg1_sign_i  (reg1_sign),
      .reg2_sign_i  (reg2_sign),
      .flush_i      (flush),
      .result_o     (result),
      .done_o       (done),
      .busy_o       (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Count edges until done_o is seen, bounded at 40.
   task automatic wait_done(output int lat, output int busy_n);
      bit seen;
      seen   = 1'b0;
      lat    = 0;
      busy_n = 0;
      while (!seen && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (busy) busy_n++;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic sa, input logic sb,
                         input logic [63:0] exp_res, input int exp_lat);
      int lat;
      int busy_n;
      mul_or_div = op;
      dividend   = a;
      divisor    = b;
      reg1_sign  = sa;
      reg2_sign  = sb;
      start      = 1'b1;
      wait_done(lat, busy_n);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " result"}, result, exp_res);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, " done width"}, done, 1'b0);
      last_busy = busy_n;
   endtask

   // mode 0: drop start, 1: flush, 2: reset, applied in the cycle where counter == at_cnt.
   task automatic abort_at(input string tag, input int at_cnt, input int mode,
                           input logic [63:0] exp_res);
      bit seen;
      mul_or_div = OP_MUL;
      dividend   = 32'd3;
      divisor    = 32'd3;
      reg1_sign  = 1'b0;
      reg2_sign  = 1'b0;
      start      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < at_cnt; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      if (mode == 0) start = 1'b0;
      else if (mode == 1) flush = 1'b1;
      else rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, " busy"}, busy, 1'b0);
      check({tag, " done"}, done, 1'b0);
      check({tag, " result"}, result, exp_res);
      start = 1'b0;
      flush = 1'b0;
      rst   = 1'b1;
      seen  = 1'b0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check({tag, " no done"}, seen, 1'b0);
   endtask

   initial begin
      int lat;
      int busy_n;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset result", result, 64'd0);
      check("reset done", done, 1'b0);
      check("reset busy", busy, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      run_op("mulu 7x6", OP_MUL, 32'h0000_0007, 32'h0000_0006, 1'b0, 1'b0,
             64'h0000_0000_0000_002A, 33);
      check("mulu busy cycles", last_busy, 33);
      run_op("mulh -2x3", OP_MUL, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFA, 33);
      run_op("mulhsu -1xmax", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
             64'hFFFF_FFFF_0000_0001, 33);
      run_op("mulhu maxxmax", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
             64'hFFFF_FFFE_0000_0001, 33);
      run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1,
             {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 33);
      run_op("div 7/-2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b1,
             {32'hFFFF_FFFD, 32'h0000_0001}, 33);
      run_op("divu 100/7", OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0,
             {32'h0000_000E, 32'h0000_0002}, 33);
      run_op("divu by zero", OP_DIV, 32'h0000_1234, 32'd0, 1'b0, 1'b0,
             {32'hFFFF_FFFF, 32'h0000_1234}, 1);
      check("div0 busy cycles", last_busy, 1);
      run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1,
             {32'h8000_0000, 32'h0000_0000}, 1);
      run_op("div -5 by zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1,
             {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 1);

      abort_at("start drop", 10, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
      abort_at("flush", 5, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
      abort_at("reset", 20, 2, 64'd0);

      // Back-to-back: start stays high through DONE with new operands.
      mul_or_div = OP_MUL;
      dividend   = 32'd5;
      divisor    = 32'd9;
      reg1_sign  = 1'b0;
      reg2_sign  = 1'b0;
      start      = 1'b1;
      wait_done(lat, busy_n);
      check("b2b first result", result, 64'd45);
      dividend = 32'd11;
      divisor  = 32'd13;
      @(posedge clk);
      @(negedge clk);
      check("b2b no accept in done", busy, 1'b0);
      check("b2b done single", done, 1'b0);
      @(posedge clk);
      @(negedge clk);
      // Operands change mid-operation and must not disturb the result.
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'h1234_5678;
      wait_done(lat, busy_n);
      check("b2b second latency", lat + 1, 33);
      check("b2b second result", result, 64'd143);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("b2b idle", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
